// File: rtl/lamp_fpu_sqrt_sched_if.sv
// Bus bundle between the FPU issue stage, the sqrt scheduler and the
// fractSqrt datapath. The slave modport is the scheduler's view; the master
// modport is the combined view of the requesters and the sqrt unit.
interface lamp_fpu_sqrt_sched_if #(
    parameter int N_REQ = 4,
    parameter int F_DW  = 7
);
    localparam int SW = 1 + F_DW;
    localparam int RW = 2 * SW;

    // requester side
    logic [N_REQ-1:0]    req_valid_i;
    logic [N_REQ-1:0]    req_ready_o;
    logic [N_REQ*SW-1:0] req_s_i;
    logic [N_REQ-1:0]    req_exp_odd_i;
    logic [N_REQ-1:0]    req_inv_i;
    logic [N_REQ-1:0]    req_special_i;
    logic [N_REQ-1:0]    rsp_valid_o;
    logic [N_REQ-1:0]    rsp_ready_i;
    logic [RW-1:0]       rsp_res_o;
    logic                rsp_err_o;
    // fractSqrt side
    logic                sq_doSqrt_o;
    logic [SW-1:0]       sq_s_o;
    logic                sq_is_exp_odd_o;
    logic                sq_invSqrt_o;
    logic                sq_special_case_o;
    logic [RW-1:0]       sq_res_i;
    logic                sq_valid_i;
    logic                busy_o;

    modport slave (
        input  req_valid_i, req_s_i, req_exp_odd_i, req_inv_i, req_special_i,
        input  rsp_ready_i, sq_res_i, sq_valid_i,
        output req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o,
        output sq_doSqrt_o, sq_s_o, sq_is_exp_odd_o, sq_invSqrt_o, sq_special_case_o,
        output busy_o
    );

    modport master (
        output req_valid_i, req_s_i, req_exp_odd_i, req_inv_i, req_special_i,
        output rsp_ready_i, sq_res_i, sq_valid_i,
        input  req_ready_o, rsp_valid_o, rsp_res_o, rsp_err_o,
        input  sq_doSqrt_o, sq_s_o, sq_is_exp_odd_o, sq_invSqrt_o, sq_special_case_o,
        input  busy_o
    );
endinterface

// File: rtl/lamp_fpu_sqrt_sched.sv
// Round-robin scheduler sharing one fractSqrt mantissa-sqrt unit among
// N_REQ requesters. One operation in flight; IDLE -> RUN -> RESP -> IDLE.
module lamp_fpu_sqrt_sched #(
    parameter int N_REQ   = 4,
    parameter int F_DW    = 7,
    parameter int TIMEOUT = 63
) (
    input  logic                        clk,
    input  logic                        rst,
    lamp_fpu_sqrt_sched_if.slave        bus
);
    localparam int SW  = 1 + F_DW;
    localparam int RW  = 2 * SW;
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP} state_t;

    state_t         r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, r_owner, w_grant, w_idx;
    logic           w_grant_vld;
    logic [SW-1:0]  r_s;
    logic           r_odd, r_inv, r_spec;
    logic [RW-1:0]  r_res;
    logic           r_err;
    logic [7:0]     r_timer;
    logic           w_hs, w_timeout;

    // cyclic search for the first valid requester at or after the rr pointer
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = IDW'((int'(r_ptr) + i) % N_REQ);
            if (!w_grant_vld && bus.req_valid_i[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = w_idx;
            end
        end
    end

    assign w_hs      = (r_state == S_IDLE) && w_grant_vld && rst;
    assign w_timeout = (r_timer == 8'(TIMEOUT));

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // next-state logic; a result in the timeout cycle still counts as success
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs) w_state_nxt = S_RUN;
            S_RUN:   if (bus.sq_valid_i || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready_i[r_owner]) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // operand/owner latch, rr pointer, run timer and result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_owner <= '0;
            r_s     <= '0;
            r_odd   <= 1'b0;
            r_inv   <= 1'b0;
            r_spec  <= 1'b0;
            r_res   <= '0;
            r_err   <= 1'b0;
            r_timer <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_hs) begin
                        r_owner <= w_grant;
                        r_ptr   <= (w_grant == IDW'(N_REQ - 1)) ? '0 : w_grant + 1'b1;
                        r_s     <= bus.req_s_i[w_grant*SW +: SW];
                        r_odd   <= bus.req_exp_odd_i[w_grant];
                        r_inv   <= bus.req_inv_i[w_grant];
                        r_spec  <= bus.req_special_i[w_grant];
                        r_res   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_timer <= r_timer + 1'b1;
                    if (bus.sq_valid_i) begin
                        r_res <= bus.sq_res_i;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_res <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs: ready only in IDLE (and out of reset), operands only during RUN,
    // response only during RESP
    always_comb begin
        bus.req_ready_o = '0;
        if (w_hs) bus.req_ready_o[w_grant] = 1'b1;
        bus.rsp_valid_o = '0;
        if (r_state == S_RESP) bus.rsp_valid_o[r_owner] = 1'b1;
        bus.rsp_res_o         = (r_state == S_RESP) ? r_res : '0;
        bus.rsp_err_o         = (r_state == S_RESP) && r_err;
        bus.sq_doSqrt_o       = (r_state == S_RUN);
        bus.sq_s_o            = (r_state == S_RUN) ? r_s : '0;
        bus.sq_is_exp_odd_o   = (r_state == S_RUN) && r_odd;
        bus.sq_invSqrt_o      = (r_state == S_RUN) && r_inv;
        bus.sq_special_case_o = (r_state == S_RUN) && r_spec;
        bus.busy_o            = (r_state != S_IDLE);
    end
endmodule
